// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute phases over a shared ALU and
// memory port and drives all datapath selects, strobes and ALU control from the current state.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       emaior,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StJal,
    StBranch
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] alu_funct;
  logic       taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Only R-type (op[5]=1) can select sub through funct7b5; addi never subtracts.
  always_comb begin
    alu_funct = AluAdd;
    case (funct3)
      3'b000:  alu_funct = (op[5] && funct7b5) ? AluSub : AluAdd;
      3'b010:  alu_funct = AluSlt;
      3'b110:  alu_funct = AluOr;
      3'b111:  alu_funct = AluAnd;
      default: alu_funct = AluAdd;
    endcase
  end

  // blt: SrcA < SrcB is neither equal nor greater.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = !Zero && !emaior;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = StFetch;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    ALUControl = AluAdd;
    illegal    = 1'b0;

    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 2'b01 : 2'b00;
        state_d = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = StFetch;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        ImmSrc  = 2'b11;
        state_d = StAluWb;
      end
      StBranch: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        ImmSrc     = 2'b10;
        PCWrite    = taken;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset holds FETCH selects but suppresses every strobe so nothing commits.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes the expected control word for every cycle of each random
// instruction; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       emaior;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .Zero      (Zero),
    .emaior    (emaior),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUControl(ALUControl),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct {
    string       name;
    logic [16:0] w;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALU, illegal}
  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sbs,
                                     input logic [1:0] is, input logic [2:0] alu,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sbs, is, alu, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
            ALUControl, illegal};
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) || (o == OP_BR) ||
           (o == OP_JAL);
  endfunction

  // ALU operation an arithmetic instruction asks for; only register-register form subtracts.
  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7);
    logic [2:0] r;
    if (f3 == 3'b010)      r = 3'b101;
    else if (f3 == 3'b110) r = 3'b011;
    else if (f3 == 3'b111) r = 3'b010;
    else if (f3 == 3'b000 && o == OP_R && f7) r = 3'b001;
    else                   r = 3'b000;
    return r;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic e);
    return (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && !z && !e);
  endfunction

  function automatic logic [16:0] w_fetch();
    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
  endfunction

  function automatic logic [16:0] w_rst();
    return mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0);
  endfunction

  function automatic logic [16:0] w_aluwb();
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
  endfunction

  task automatic push(input string nm, input logic [16:0] w);
    ent_t en;
    en.name = nm;
    en.w    = w;
    sb.push_back(en);
  endtask

  task automatic step(input string nm, input logic [16:0] w, input logic z, input logic e);
    Zero   = z;
    emaior = e;
    push(nm, w);
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input string nm, input logic [16:0] w);
    step(nm, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    logic z, e;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    rstep("fetch", w_fetch());
    rstep("decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, !is_legal(o)));
    if (o == OP_LW) begin
      rstep("lw_adr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
      rstep("lw_read", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      rstep("lw_wb", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    end else if (o == OP_SW) begin
      rstep("sw_adr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
      rstep("sw_write", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    end else if (o == OP_R) begin
      rstep("execr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, ref_alu(o, f3, f7), 0));
      rstep("r_wb", w_aluwb());
    end else if (o == OP_I) begin
      rstep("execi", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, ref_alu(o, f3, f7), 0));
      rstep("i_wb", w_aluwb());
    end else if (o == OP_BR) begin
      z = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      step("branch", mk(ref_taken(f3, z, e), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0),
           z, e);
    end else if (o == OP_JAL) begin
      rstep("jal", mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
      rstep("jal_wb", w_aluwb());
    end
  endtask

  task automatic run_random();
    logic [6:0] o;
    case ($urandom_range(0, 6))
      0: o = OP_LW;
      1: o = OP_SW;
      2: o = OP_R;
      3: o = OP_I;
      4: o = OP_BR;
      5: o = OP_JAL;
      default: begin
        o = 7'($urandom_range(0, 127));
        while (is_legal(o)) o = 7'($urandom_range(0, 127));
      end
    endcase
    run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  initial begin : monitor
    ent_t        en;
    logic [16:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        en  = sb.pop_front();
        got = observed();
        checks++;
        if (got !== en.w) begin
          errors++;
          $display("FAIL %s @%0t: got %b required %b (op=%b f3=%b f7=%b Z=%b gt=%b)", en.name,
                   $time, got, en.w, op, funct3, funct7b5, Zero, emaior);
        end
      end
    end
  end

  initial begin : stimulus
    reset    = 1'b1;
    op       = 7'd0;
    funct3   = 3'd0;
    funct7b5 = 1'b0;
    Zero     = 1'b0;
    emaior   = 1'b0;
    @(posedge clk);
    #1;
    push("reset_hold", w_rst());
    @(posedge clk);
    #1;
    push("reset_hold", w_rst());
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(OP_LW, 3'b010, 1'b0);
    run_instr(OP_R, 3'b000, 1'b1);
    run_instr(OP_I, 3'b000, 1'b1);
    run_instr(OP_BR, 3'b100, 1'b0);
    run_instr(OP_JAL, 3'b000, 1'b0);
    run_instr(7'b1111111, 3'b000, 1'b0);

    // Reset arrives while MEMWRITE is driving the write strobe.
    op       = OP_SW;
    funct3   = 3'b010;
    funct7b5 = 1'b0;
    rstep("fetch", w_fetch());
    rstep("decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0));
    rstep("sw_adr", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    push("sw_write", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    #6;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== w_rst()) begin
      errors++;
      $display("FAIL async_reset_memwrite: got %b required %b", observed(), w_rst());
    end
    @(posedge clk);
    #1;
    push("reset_mid", w_rst());
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 400; i++) run_random();

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM that turns the team's RISC-V datapath into a multicycle machine sharing one ALU and one memory port across fetch, address and data phases. It decodes the latched instruction fields each cycle and drives every datapath select, write-enable and ALU-control line. ALU flags (`Zero`, `emaior`) are consumed for branch resolution. It sits beside the datapath inside the CPU top level. Its only state is the FSM register.

## Interface
Parameters: none.

Reset is asynchronous and active-high. There is one clock.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; forces the FSM to FETCH.
- `op` input 7: instruction opcode, Instr[6:0].
- `funct3` input 3: Instr[14:12].
- `funct7b5` input 1: Instr[30].
- `Zero` input 1: ALU result == 0.
- `emaior` input 1: ALU flag, 1 when SrcA > SrcB (signed).
- `PCWrite` output 1: PC register load enable.
- `AdrSrc` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemWrite` output 1: data memory write strobe.
- `IRWrite` output 1: instruction and OldPC register load.
- `RegWrite` output 1: register file write.
- `ResultSrc` output 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB` output 2: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` output 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` output 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `illegal` output 1: one-cycle pulse in DECODE for an unsupported opcode.

## Operation
- State register, Moore-style outputs. All outputs are combinational from the state, plus `op`, `funct3` and the flags. Unlisted outputs are 0 and ALU op defaults to add.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (branch target into ALUOut). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → FETCH, with `illegal`=1 (the instruction is treated as a nop).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=00 for lw / 01 for sw. Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU op decoded from funct. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALU op decoded from funct. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 (PC ← target), PCWrite=1, ImmSrc=11. Next state: ALUWB, which writes OldPC+4.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, ImmSrc=10. PCWrite=taken. Next state: FETCH.
  - taken rules: funct3 000 (beq) → Zero; 001 (bne) → !Zero; 100 (blt) → !Zero & !emaior; any other funct3 → 0.
- Funct ALU decode (by funct3):
  - 000 → sub only when op[5]=1 and funct7b5=1, else add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - any other → add.
- State encoding is free. Unreachable encodings must return to FETCH on the next clock.

## Timing
- `reset` high: state becomes FETCH immediately (asynchronous). While `reset` is high, PCWrite, IRWrite, MemWrite, RegWrite and `illegal` are forced to 0; the other outputs take their FETCH values.
- Reset release: the first active FETCH happens on the first rising edge with `reset` low.
- Cycles per instruction, counted from FETCH to the next FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - I-type 4
  - branch 3
  - jal 4
  - illegal opcode 2
- A strobe such as MemWrite or RegWrite is high for exactly one cycle per instruction.
- Reset asserted mid-instruction, e.g. in MEMWRITE: the strobe drops in the same cycle and no partial write is committed on later edges.
- `Zero` and `emaior` are sampled only in BRANCH, in the same cycle as PCWrite.

## Test plan
- Reset, then lw (op=0000011): states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; IRWrite=1 only in cycle 1.
- sw (op=0100011): MemWrite=1 in cycle 4 with AdrSrc=1, ImmSrc=01 in MEMADR; RegWrite never 1.
- R-type sub (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECR. addi with funct7b5=1: ALUControl=000. funct3=111: 010. funct3=110: 011. funct3=010: 101.
- Branch in BRANCH state:
  - beq with Zero=1 → PCWrite=1; with Zero=0 → PCWrite=0.
  - bne with Zero=0 → PCWrite=1.
  - blt with Zero=0, emaior=0 → PCWrite=1; with emaior=1 → PCWrite=0.
  - funct3=010 → PCWrite=0.
- jal (op=1101111): PCWrite=1 in JAL with ALUSrcA=01, ALUSrcB=10; next cycle ALUWB asserts RegWrite=1. The next FETCH follows in cycle 5.
- op=1111111: `illegal`=1 in DECODE, back to FETCH the next cycle, no write strobes. Reset asserted during MEMWRITE: MemWrite drops to 0 combinationally and the FSM restarts at FETCH after release.
